// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the Data_Memory port arbiter.
//   - REG_LEN / DM_UNIT_MASK mirror the CPU-wide address width and line mask,
//     and they supply the default address and line widths.
//   - arb_state_t is the arbiter FSM encoding: IDLE, GNT0 and GNT1.
//   - grant_of() turns a state into the one-hot owner vector.
package mem_arbiter_pkg;

  localparam int REG_LEN      = 32;
  localparam int DM_UNIT_MASK = 255;

  localparam int ARB_ADDR_W = REG_LEN;
  localparam int ARB_DATA_W = DM_UNIT_MASK + 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // Bit 0 is set when port 0 owns memory, bit 1 when port 1 owns it.
  // The result is 00 while the arbiter is idle.
  function automatic logic [1:0] grant_of(input arb_state_t s);
    return {s == ARB_GNT1, s == ARB_GNT0};
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog
//   Watchdog that flags a memory which never acknowledges. It holds a
//   saturating wait counter and a sticky error flag.
//   Ports:
//     clk_i, rst_i : clock and synchronous active-high reset
//     clear        : restart the count (a grant is being issued)
//     count_en     : a grant cycle that passed without an ack
//     timeout      : sticky error; only rst_i clears it
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // count holds the number of ack-less grant cycles already completed.
  // The cycle in progress is therefore grant cycle count+1.
  // The flag is set at the end of grant cycle TIMEOUT-1, so timeout is
  // already high during grant cycle TIMEOUT.
  // The counter stops at TIMEOUT-1. Counting past that point adds nothing.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (count_en && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
      if (count_en && (count >= CNT_TRIP)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one Data_Memory port between two cache-refill masters, using
//   round-robin arbitration. Port 0 is the dcache controller and port 1 is
//   the icache refill.
//   Ports:
//     clk_i, rst_i          clock and synchronous active-high reset
//     mX_enable_i           request; the master holds it high until mX_ack_o
//     mX_write_i            1 = line write, 0 = line read
//     mX_addr_i, mX_data_i  line address and write data
//     mX_ack_o              single-cycle completion pulse, sent to the owner only
//     mX_data_o             read data, broadcast from memory
//     mem_*                 toward data_memory; held stable for the whole grant
//     grant_o               one-hot owner; 00 when idle (this also exposes FSM state)
//     timeout_o             sticky watchdog error
//   Handshake: a master raises enable and holds it. The arbiter latches that
//   request on the grant edge and keeps mem_enable_o high until it samples
//   mem_ack_i. In the same cycle as that ack, the owner gets mX_ack_o.
//   Enable falls at the ack edge. At least one idle cycle always follows a
//   transaction before the next grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,

  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  arb_state_t state, state_d;
  logic       last;       // port that received the most recent grant
  logic       grant_now;  // IDLE is issuing a grant on this edge
  logic       pick1;      // the grant being issued goes to port 1
  logic       in_grant;

  assign in_grant = (state == ARB_GNT0) || (state == ARB_GNT1);

  // Next-state and round-robin pick. When both ports request, the grant
  // goes to the port that did not win last time.
  always_comb begin
    state_d   = state;
    grant_now = 1'b0;
    pick1     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          grant_now = 1'b1;
          pick1     = m1_enable_i && (!m0_enable_i || !last);
          state_d   = pick1 ? ARB_GNT1 : ARB_GNT0;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (mem_ack_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // mem_* outputs come only from the copy latched at grant time. A master
  // that changes or drops its inputs during the grant has no effect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ARB_IDLE;
      last         <= 1'b1;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state <= state_d;
      if (grant_now) begin
        mem_enable_o <= 1'b1;
        mem_write_o  <= pick1 ? m1_write_i : m0_write_i;
        mem_addr_o   <= pick1 ? m1_addr_i  : m0_addr_i;
        mem_data_o   <= pick1 ? m1_data_i  : m0_data_i;
      end else if (in_grant && mem_ack_i) begin
        mem_enable_o <= 1'b0;
        last         <= (state == ARB_GNT1);
      end
    end
  end

  // An ack that arrives while idle is never forwarded to a master.
  assign m0_ack_o  = mem_ack_i && (state == ARB_GNT0);
  assign m1_ack_o  = mem_ack_i && (state == ARB_GNT1);
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
  assign grant_o   = grant_of(state);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (grant_now),
    .count_en (in_grant && !mem_ack_i),
    .timeout  (timeout_o)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter, built with TIMEOUT = 8.
//   - Inputs are driven and cycle checks are made on the falling edge.
//   - The memory responder acts 2 time units after the rising edge.
//   - The monitor pops the expected {port, line} entry for every ack.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;
  localparam int W      = DATA_W;
  localparam int EXP_W  = DATA_W + 1;

  logic              clk_i;
  logic              rst_i;
  logic              m0_enable_i, m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_data_o;
  logic              m1_enable_i, m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  wire               mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [1:0]        grant_o;
  logic              timeout_o;

  logic resp_ack;
  logic poke_ack;
  assign mem_ack_i = resp_ack | poke_ack;

  int   checks = 0;
  int   errors = 0;
  int   mem_latency = 10;
  logic mem_auto = 1'b1;

  logic [EXP_W-1:0] exp_q[$];

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_enable_i (m0_enable_i),
    .m0_write_i  (m0_write_i),
    .m0_addr_i   (m0_addr_i),
    .m0_data_i   (m0_data_i),
    .m0_ack_o    (m0_ack_o),
    .m0_data_o   (m0_data_o),
    .m1_enable_i (m1_enable_i),
    .m1_write_i  (m1_write_i),
    .m1_addr_i   (m1_addr_i),
    .m1_data_i   (m1_data_i),
    .m1_ack_o    (m1_ack_o),
    .m1_data_o   (m1_data_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .grant_o     (grant_o),
    .timeout_o   (timeout_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Memory line content that the responder returns for a given address.
  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5A5A_3C3C}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  // The responder counts the cycles that enable has been high. When the
  // count reaches mem_latency, it raises ack for exactly one cycle.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    resp_ack   = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      resp_ack = 1'b0;
      if (!mem_enable_o) begin
        wait_cnt = 0;
      end else if (mem_auto) begin
        wait_cnt++;
        if (wait_cnt == mem_latency) begin
          resp_ack   = 1'b1;
          mem_data_i = line_of(mem_addr_o);
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (m0_ack_o || m1_ack_o) begin
        check("dual_ack", W'(m0_ack_o & m1_ack_o), W'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack m0=%0b m1=%0b expected none", m0_ack_o, m1_ack_o);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", W'(m1_ack_o), W'(e[DATA_W]));
          check("ack_data", m1_ack_o ? m1_data_o : m0_data_o, e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    poke_ack    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int a0, a1, ngr, idle_run;
    logic [1:0] prev_g;
    logic [1:0] order[4];

    rst_i = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    check("rst_grant",   W'(grant_o),      W'(0));
    check("rst_en",      W'(mem_enable_o), W'(0));
    check("rst_write",   W'(mem_write_o),  W'(0));
    check("rst_addr",    W'(mem_addr_o),   W'(0));
    check("rst_data",    mem_data_o,       W'(0));
    check("rst_timeout", W'(timeout_o),    W'(0));
    check("rst_ack",     W'({m1_ack_o, m0_ack_o}), W'(0));
    rst_i = 1'b0;

    // Test 1: port 0 read of 0x400. Memory acks on the 10th enable cycle.
    mem_latency = 10;
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
    m0_data_i   = {8{32'h1111_2222}};
    exp_q.push_back({1'b0, line_of(32'h0000_0400)});
    check("t1_en_pre", W'(mem_enable_o), W'(0));
    @(negedge clk_i);
    check("t1_en",    W'(mem_enable_o), W'(1));
    check("t1_addr",  W'(mem_addr_o),   W'(32'h400));
    check("t1_write", W'(mem_write_o),  W'(0));
    check("t1_grant", W'(grant_o),      W'(2'b01));
    n = 1;
    while (!m0_ack_o && n < 40) begin
      @(negedge clk_i);
      n++;
      check("t1_grant_hold", W'(grant_o), W'(2'b01));
    end
    check("t1_ack_cycle", W'(n), W'(10));
    check("t1_m1_ack", W'(m1_ack_o), W'(0));
    m0_enable_i = 1'b0;
    @(negedge clk_i);
    check("t1_grant_after", W'(grant_o),      W'(0));
    check("t1_en_after",    W'(mem_enable_o), W'(0));
    check("t1_ack_after",   W'(m0_ack_o),     W'(0));

    // Test 2: both ports request continuously for 4 transactions.
    // Expected grant order is 0,1,0,1 with one idle cycle between grants.
    do_reset();
    mem_latency = 3;
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_addr_i = 32'h0000_1000;
    m1_enable_i = 1'b1; m1_addr_i = 32'h0000_2000;
    exp_q.push_back({1'b0, line_of(32'h0000_1000)});
    exp_q.push_back({1'b1, line_of(32'h0000_2000)});
    exp_q.push_back({1'b0, line_of(32'h0000_1040)});
    exp_q.push_back({1'b1, line_of(32'h0000_2040)});
    a0 = 0; a1 = 0; ngr = 0; idle_run = 0; prev_g = 2'b00;
    for (int i = 0; i < 4; i++) order[i] = 2'b00;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_i);
      check("t2_en_vs_grant", W'(mem_enable_o), W'(grant_o != 2'b00));
      if (grant_o != 2'b00 && prev_g == 2'b00) begin
        if (ngr < 4) order[ngr] = grant_o;
        if (ngr > 0) check("t2_gap", W'(idle_run), W'(1));
        ngr++;
        idle_run = 0;
      end else if (grant_o == 2'b00) begin
        idle_run++;
      end
      prev_g = grant_o;
      if (m0_ack_o) begin
        a0++;
        if (a0 == 2) m0_enable_i = 1'b0;
        else m0_addr_i = 32'h0000_1040;
      end
      if (m1_ack_o) begin
        a1++;
        if (a1 == 2) m1_enable_i = 1'b0;
        else m1_addr_i = 32'h0000_2040;
      end
      if (ngr >= 4 && grant_o == 2'b00) break;
    end
    check("t2_ngrants", W'(ngr),      W'(4));
    check("t2_order0",  W'(order[0]), W'(2'b01));
    check("t2_order1",  W'(order[1]), W'(2'b10));
    check("t2_order2",  W'(order[2]), W'(2'b01));
    check("t2_order3",  W'(order[3]), W'(2'b10));
    idle_inputs();

    // Test 3: port 1 writes 0x800 / A5...A5. Two cycles into the grant,
    // the master puts garbage on its inputs and drops enable.
    mem_latency = 6;
    @(negedge clk_i);
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_0800;
    m1_data_i   = {32{8'hA5}};
    exp_q.push_back({1'b1, line_of(32'h0000_0800)});
    @(negedge clk_i);
    check("t3_grant", W'(grant_o),     W'(2'b10));
    check("t3_write", W'(mem_write_o), W'(1));
    @(negedge clk_i);
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'hDEAD_0000;
    m1_data_i   = {8{32'h0BAD_F00D}};
    n = 2;
    while (!m1_ack_o && n < 40) begin
      @(negedge clk_i);
      n++;
      check("t3_addr_hold",  W'(mem_addr_o),   W'(32'h800));
      check("t3_data_hold",  mem_data_o,       {32{8'hA5}});
      check("t3_write_hold", W'(mem_write_o),  W'(1));
      check("t3_en_hold",    W'(mem_enable_o), W'(1));
    end
    check("t3_ack_cycle", W'(n), W'(6));
    idle_inputs();
    @(negedge clk_i);
    check("t3_idle", W'(grant_o), W'(0));

    // Test 4: an ack pulse while the arbiter is idle is ignored.
    @(negedge clk_i);
    poke_ack = 1'b1;
    #1;
    check("t4_no_ack", W'({m1_ack_o, m0_ack_o}), W'(0));
    @(negedge clk_i);
    poke_ack = 1'b0;
    check("t4_still_idle", W'(grant_o),      W'(0));
    check("t4_en",         W'(mem_enable_o), W'(0));

    // Test 5: the memory never acks. timeout_o rises in grant cycle 8 and
    // stays high until rst_i clears it.
    do_reset();
    mem_auto = 1'b0;
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0C00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      check("t5_timeout", W'(timeout_o), W'(k >= 8));
    end
    check("t5_still_grant", W'(grant_o), W'(2'b01));
    rst_i = 1'b1;
    m0_enable_i = 1'b0;
    @(negedge clk_i);
    check("t5_rst_timeout", W'(timeout_o),    W'(0));
    check("t5_rst_en",      W'(mem_enable_o), W'(0));
    check("t5_rst_grant",   W'(grant_o),      W'(0));
    rst_i = 1'b0;
    mem_auto = 1'b1;

    // Test 6: rst_i is asserted in grant cycle 3 of a port 0 read. No ack
    // should appear, and after the reset port 0 should win a tie.
    mem_latency = 10;
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0600;
    repeat (3) @(negedge clk_i);
    check("t6_grant_mid", W'(grant_o), W'(2'b01));
    rst_i = 1'b1;
    m0_enable_i = 1'b0;
    @(negedge clk_i);
    check("t6_grant", W'(grant_o),      W'(0));
    check("t6_en",    W'(mem_enable_o), W'(0));
    check("t6_ack",   W'({m1_ack_o, m0_ack_o}), W'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0700;
    m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0740;
    exp_q.push_back({1'b0, line_of(32'h0000_0700)});
    @(negedge clk_i);
    check("t6_tie_winner", W'(grant_o), W'(2'b01));
    m1_enable_i = 1'b0;
    n = 1;
    while (!m0_ack_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_ack_seen", W'(m0_ack_o), W'(1));
    idle_inputs();

    repeat (5) @(negedge clk_i);
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
